// File: rtl/yildiz_uart_io.sv
`default_nettype none
// ============================================================================
// Module   : yildiz_uart_io
// Brief    : 8N1 UART front-end for the CPU INPR/OUTPR path (RX FIFO + TX).
//            Optional internal loopback when UART_LOOPBACK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module yildiz_uart_io #(
    parameter int CLKS_PER_BIT  = 16,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic       clkn,
    input  logic       rstn,
`ifdef UART_LOOPBACK_EN
    input  logic       loopback,
`endif
    input  logic       rx,
    output logic       tx,
    output logic [7:0] inpr,
    output logic       fgi,
    input  logic       inp_ack,
    input  logic [7:0] outpr,
    input  logic       out_wr,
    output logic       fgo,
    output logic       rx_overrun,
    output logic       frame_err,
    input  logic       err_clr
);

    localparam int c_baudW = $clog2(CLKS_PER_BIT);
    localparam int c_ptrW  = $clog2(RX_FIFO_DEPTH);
    localparam int c_cntW  = c_ptrW + 1;

    localparam logic [c_baudW-1:0] c_baudMax  = c_baudW'(CLKS_PER_BIT - 1);
    localparam logic [c_baudW-1:0] c_baudHalf = c_baudW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_baudW-1:0] c_baudOne  = c_baudW'(1);
    localparam logic [c_cntW-1:0]  c_fullCnt  = c_cntW'(RX_FIFO_DEPTH);
    localparam logic [c_cntW-1:0]  c_cntOne   = c_cntW'(1);
    localparam logic [c_ptrW-1:0]  c_ptrOne   = c_ptrW'(1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rxState_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } txState_t;

    // ------------------------------------------------------------------------
    // RX line conditioning
    // ------------------------------------------------------------------------
    logic r_rxMeta;
    logic r_rxSync;
    logic r_linePrev;
    logic r_tx;
    logic w_rxLine;

`ifdef UART_LOOPBACK_EN
    assign w_rxLine = loopback ? r_tx : r_rxSync;
`else
    assign w_rxLine = r_rxSync;
`endif

    always_ff @(posedge clkn) begin
        if (!rstn) begin
            r_rxMeta   <= 1'b1;
            r_rxSync   <= 1'b1;
            r_linePrev <= 1'b1;
        end else begin
            r_rxMeta   <= rx;
            r_rxSync   <= r_rxMeta;
            r_linePrev <= w_rxLine;
        end
    end

    // ------------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------------
    rxState_t           r_rxState, w_rxStateNext;
    logic [c_baudW-1:0] r_rxBaud, w_rxBaudNext;
    logic [2:0]         r_rxBit, w_rxBitNext;
    logic [7:0]         r_rxShift, w_rxShiftNext;
    logic               w_push;
    logic               w_frameErrSet;

    always_ff @(posedge clkn) begin
        if (!rstn) begin
            r_rxState <= RX_IDLE;
            r_rxBaud  <= '0;
            r_rxBit   <= '0;
            r_rxShift <= '0;
        end else begin
            r_rxState <= w_rxStateNext;
            r_rxBaud  <= w_rxBaudNext;
            r_rxBit   <= w_rxBitNext;
            r_rxShift <= w_rxShiftNext;
        end
    end

    always_comb begin
        w_rxStateNext = r_rxState;
        w_rxBaudNext  = r_rxBaud;
        w_rxBitNext   = r_rxBit;
        w_rxShiftNext = r_rxShift;
        w_push        = 1'b0;
        w_frameErrSet = 1'b0;
        case (r_rxState)
            RX_IDLE: begin
                w_rxBaudNext = '0;
                if (r_linePrev && !w_rxLine) begin
                    w_rxStateNext = RX_START;
                end
            end
            RX_START: begin
                // Mid-start-bit recheck rejects short glitches on the idle line.
                if (r_rxBaud == c_baudHalf) begin
                    w_rxBaudNext  = '0;
                    w_rxBitNext   = '0;
                    w_rxStateNext = w_rxLine ? RX_IDLE : RX_DATA;
                end else begin
                    w_rxBaudNext = r_rxBaud + c_baudOne;
                end
            end
            RX_DATA: begin
                if (r_rxBaud == c_baudMax) begin
                    w_rxBaudNext  = '0;
                    w_rxShiftNext = {w_rxLine, r_rxShift[7:1]};
                    if (r_rxBit == 3'd7) begin
                        w_rxStateNext = RX_STOP;
                    end else begin
                        w_rxBitNext = r_rxBit + 3'd1;
                    end
                end else begin
                    w_rxBaudNext = r_rxBaud + c_baudOne;
                end
            end
            RX_STOP: begin
                if (r_rxBaud == c_baudMax) begin
                    w_rxBaudNext  = '0;
                    w_rxStateNext = RX_IDLE;
                    w_push        = w_rxLine;
                    w_frameErrSet = !w_rxLine;
                end else begin
                    w_rxBaudNext = r_rxBaud + c_baudOne;
                end
            end
            default: w_rxStateNext = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // RX FIFO and sticky error flags
    // ------------------------------------------------------------------------
    logic [7:0]        r_mem [RX_FIFO_DEPTH];
    logic [c_ptrW-1:0] r_wrPtr;
    logic [c_ptrW-1:0] r_rdPtr;
    logic [c_cntW-1:0] r_count;
    logic              r_rxOverrun;
    logic              r_frameErr;
    logic              w_pop;
    logic              w_full;
    logic              w_pushOk;
    logic              w_overrunSet;

    assign w_pop        = inp_ack && (r_count != '0);
    assign w_full       = (r_count == c_fullCnt);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_pushOk     = w_push && (!w_full || w_pop);
    assign w_overrunSet = w_push && w_full && !w_pop;

    always_ff @(posedge clkn) begin
        if (!rstn) begin
            for (int i = 0; i < RX_FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_pushOk) begin
                r_mem[r_wrPtr] <= r_rxShift;
                r_wrPtr        <= r_wrPtr + c_ptrOne;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_ptrOne;
            end
            if (w_pushOk && !w_pop) begin
                r_count <= r_count + c_cntOne;
            end else if (!w_pushOk && w_pop) begin
                r_count <= r_count - c_cntOne;
            end
        end
    end

    always_ff @(posedge clkn) begin
        if (!rstn) begin
            r_rxOverrun <= 1'b0;
            r_frameErr  <= 1'b0;
        end else begin
            if (w_overrunSet) begin
                r_rxOverrun <= 1'b1;
            end else if (err_clr) begin
                r_rxOverrun <= 1'b0;
            end
            if (w_frameErrSet) begin
                r_frameErr <= 1'b1;
            end else if (err_clr) begin
                r_frameErr <= 1'b0;
            end
        end
    end

    assign inpr       = r_mem[r_rdPtr];
    assign fgi        = (r_count != '0);
    assign rx_overrun = r_rxOverrun;
    assign frame_err  = r_frameErr;

    // ------------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------------
    txState_t           r_txState, w_txStateNext;
    logic [c_baudW-1:0] r_txBaud, w_txBaudNext;
    logic [2:0]         r_txBit, w_txBitNext;
    logic [7:0]         r_txShift, w_txShiftNext;
    logic               w_txNext;

    always_ff @(posedge clkn) begin
        if (!rstn) begin
            r_txState <= TX_IDLE;
            r_txBaud  <= '0;
            r_txBit   <= '0;
            r_txShift <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_txState <= w_txStateNext;
            r_txBaud  <= w_txBaudNext;
            r_txBit   <= w_txBitNext;
            r_txShift <= w_txShiftNext;
            r_tx      <= w_txNext;
        end
    end

    always_comb begin
        w_txStateNext = r_txState;
        w_txBaudNext  = r_txBaud;
        w_txBitNext   = r_txBit;
        w_txShiftNext = r_txShift;
        w_txNext      = r_tx;
        case (r_txState)
            TX_IDLE: begin
                w_txNext     = 1'b1;
                w_txBaudNext = '0;
                if (out_wr) begin
                    w_txStateNext = TX_START;
                    w_txShiftNext = outpr;
                    w_txNext      = 1'b0;
                end
            end
            TX_START: begin
                if (r_txBaud == c_baudMax) begin
                    w_txBaudNext  = '0;
                    w_txBitNext   = '0;
                    w_txStateNext = TX_DATA;
                    w_txNext      = r_txShift[0];
                end else begin
                    w_txBaudNext = r_txBaud + c_baudOne;
                end
            end
            TX_DATA: begin
                if (r_txBaud == c_baudMax) begin
                    w_txBaudNext = '0;
                    if (r_txBit == 3'd7) begin
                        w_txStateNext = TX_STOP;
                        w_txNext      = 1'b1;
                    end else begin
                        w_txBitNext   = r_txBit + 3'd1;
                        w_txShiftNext = {1'b0, r_txShift[7:1]};
                        w_txNext      = r_txShift[1];
                    end
                end else begin
                    w_txBaudNext = r_txBaud + c_baudOne;
                end
            end
            TX_STOP: begin
                if (r_txBaud == c_baudMax) begin
                    w_txBaudNext  = '0;
                    w_txStateNext = TX_IDLE;
                end else begin
                    w_txBaudNext = r_txBaud + c_baudOne;
                end
            end
            default: w_txStateNext = TX_IDLE;
        endcase
    end

    assign tx  = r_tx;
    assign fgo = (r_txState == TX_IDLE);

endmodule
`default_nettype wire
